id_stage: RTL and testbench

- Decode/operand stage directly upstream of the 64-bit execute ALU.
- Accepts 32-bit RV64I instructions over a valid/ready handshake and decodes OP, OP-IMM and LUI.
- Reads operands from an internal 32x64 register file, which is written by the writeback port.
- Presents registered op1/op2/funct3/funct7/imm to the ALU; a pending-write scoreboard stalls RAW hazards.

---
 rtl/id_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : decode / operand stage feeding the 64-bit execute ALU.
//
// Decodes RV64I OP, OP-IMM and LUI instructions, reads operands from an
// internal NREGS x XLEN register file (written by the writeback port) and
// presents a registered operand bundle to the ALU. A per-register pending
// bit (scoreboard) holds off instructions whose sources are still in flight.
//
// Build option:
//   ID_WB_BYPASS_EN - when defined, a writeback arriving in the same cycle is
//                     forwarded to the operand read and clears the hazard in
//                     that cycle. When undefined, reads and hazard checks use
//                     registered state only (dependent op issues one cycle
//                     after writeback).
//
// Ports:
//   CLK, RST            clock (rising edge) / asynchronous active-high reset
//   inst_valid, inst    upstream instruction handshake (in)
//   inst_ready          stage can accept an instruction this cycle (out)
//   ex_stall            ALU cannot take a new operand bundle (in)
//   wb_en, wb_rd,
//   wb_data             register file write port (in)
//   op1, op2            ALU operands (op2 = rs2 value or immediate)
//   funct3, funct7      ALU function selects
//   imm                 op2 carries an immediate
//   rd_out              destination register of the issued op
//   alu_valid           output bundle valid
//   illegal             one-cycle pulse on acceptance of an unsupported opcode
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic            inst_ready,
    input  logic            ex_stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            imm,
    output logic [4:0]      rd_out,
    output logic            alu_valid,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    // Sign-extend the 12-bit I-type immediate.
    function automatic logic signed [XLEN-1:0] sext_i(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

    // Sign-extend the 20-bit U-type immediate after placing it at [31:12].
    function automatic logic signed [XLEN-1:0] sext_u(input logic [19:0] v);
        return {{(XLEN-32){v[19]}}, v, 12'b0};
    endfunction

    // Architectural state
    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] pend_q;

    // Output bundle registers
    logic [XLEN-1:0] op1_p1;
    logic [XLEN-1:0] op2_p1;
    logic [2:0]      f3_p1;
    logic [6:0]      f7_p1;
    logic            imm_p1;
    logic [4:0]      rd_p1;
    logic            vld_p1;
    logic            ill_p1;

    // ---- stage p0: decode, operand read, hazard ----
    logic [6:0] opc_p0;
    logic [4:0] rs1_p0;
    logic [4:0] rs2_p0;
    logic [4:0] rd_p0;
    logic [2:0] f3raw_p0;
    logic       is_op_p0;
    logic       is_opimm_p0;
    logic       is_lui_p0;
    logic       legal_p0;
    logic       is_shift_p0;

    assign opc_p0      = inst[6:0];
    assign rd_p0       = inst[11:7];
    assign f3raw_p0    = inst[14:12];
    assign rs1_p0      = inst[19:15];
    assign rs2_p0      = inst[24:20];
    assign is_op_p0    = (opc_p0 == OPC_OP);
    assign is_opimm_p0 = (opc_p0 == OPC_OPIMM);
    assign is_lui_p0   = (opc_p0 == OPC_LUI);
    assign legal_p0    = is_op_p0 || is_opimm_p0 || is_lui_p0;
    assign is_shift_p0 = is_opimm_p0 && (f3raw_p0 == 3'b001 || f3raw_p0 == 3'b101);

    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] pend_view;
    logic [XLEN-1:0]  rv1_p0;
    logic [XLEN-1:0]  rv2_p0;
    logic             hazard;
    logic             advance;
    logic             fire;

    always_comb begin
        clr_vec = '0;
        if (wb_en) begin
            clr_vec[wb_rd] = 1'b1;
        end
    end

    // Register read; x0 is always zero regardless of file contents.
    always_comb begin
        rv1_p0 = '0;
        rv2_p0 = '0;
        if (rs1_p0 != 5'd0) begin
            rv1_p0 = rf[rs1_p0];
        end
        if (rs2_p0 != 5'd0) begin
            rv2_p0 = rf[rs2_p0];
        end
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == rs1_p0 && rs1_p0 != 5'd0) begin
            rv1_p0 = wb_data;
        end
        if (wb_en && wb_rd == rs2_p0 && rs2_p0 != 5'd0) begin
            rv2_p0 = wb_data;
        end
`endif
    end

`ifdef ID_WB_BYPASS_EN
    // A writeback landing this cycle already satisfies its dependents.
    assign pend_view = pend_q & ~clr_vec;
`else
    assign pend_view = pend_q;
`endif

    // rs1 is a source for OP and OP-IMM, rs2 only for OP; LUI has none.
    assign hazard = ((is_op_p0 || is_opimm_p0) && rs1_p0 != 5'd0 && pend_view[rs1_p0]) ||
                    (is_op_p0 && rs2_p0 != 5'd0 && pend_view[rs2_p0]);

    assign advance    = !vld_p1 || !ex_stall;
    assign inst_ready = advance && !hazard;
    assign fire       = inst_valid && inst_ready;

    always_comb begin
        set_vec = '0;
        if (fire && legal_p0 && rd_p0 != 5'd0) begin
            set_vec[rd_p0] = 1'b1;
        end
    end

    // Bundle formation
    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic [2:0]      f3_d;
    logic [6:0]      f7_d;
    logic            imm_d;

    always_comb begin
        op1_d = rv1_p0;
        op2_d = rv2_p0;
        f3_d  = f3raw_p0;
        f7_d  = '0;
        imm_d = 1'b0;
        if (is_op_p0) begin
            f7_d = inst[31:25];
        end else if (is_opimm_p0) begin
            imm_d = 1'b1;
            if (is_shift_p0) begin
                // Shift amount is zero-extended; bit 25 belongs to shamt,
                // so only inst[31:26] carries the arithmetic-shift flag.
                op2_d = {{(XLEN-6){1'b0}}, inst[25:20]};
                f7_d  = {inst[31:26], 1'b0};
            end else begin
                op2_d = sext_i(inst[31:20]);
            end
        end else if (is_lui_p0) begin
            op1_d = '0;
            op2_d = sext_u(inst[31:12]);
            f3_d  = 3'b000;
            imm_d = 1'b1;
        end
    end

    // ---- stage p1: registered state and ALU bundle ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Set wins over a same-cycle clear on the same index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1 <= 1'b0;
            ill_p1 <= 1'b0;
            op1_p1 <= '0;
            op2_p1 <= '0;
            f3_p1  <= '0;
            f7_p1  <= '0;
            imm_p1 <= 1'b0;
            rd_p1  <= '0;
        end else begin
            ill_p1 <= fire && !legal_p0;
            if (advance) begin
                if (fire && legal_p0) begin
                    vld_p1 <= 1'b1;
                    op1_p1 <= op1_d;
                    op2_p1 <= op2_d;
                    f3_p1  <= f3_d;
                    f7_p1  <= f7_d;
                    imm_p1 <= imm_d;
                    rd_p1  <= rd_p0;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end
        end
    end

    assign op1       = op1_p1;
    assign op2       = op2_p1;
    assign funct3    = f3_p1;
    assign funct7    = f7_p1;
    assign imm       = imm_p1;
    assign rd_out    = rd_p1;
    assign alu_valid = vld_p1;
    assign illegal   = ill_p1;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    localparam int XLEN = 64;
`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic            inst_valid;
    logic [31:0]     inst;
    logic            inst_ready;
    logic            ex_stall;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            imm;
    logic [4:0]      rd_out;
    logic            alu_valid;
    logic            illegal;

    id_stage #(.XLEN(XLEN), .NREGS(32)) dut (
        .CLK(CLK), .RST(RST), .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .ex_stall(ex_stall), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .op1(op1), .op2(op2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .rd_out(rd_out),
        .alu_valid(alu_valid), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned mregs [32];
    bit              mpend [32];
    bit              e_valid, e_ill, e_imm;
    longint unsigned e_op1, e_op2;
    int              e_f3, e_f7, e_rd;

    function automatic bit pend_seen(input int r);
        if (r == 0) return 1'b0;
        if (BYP && wb_en && int'(wb_rd) == r) return 1'b0;
        return mpend[r];
    endfunction

    function automatic longint unsigned read_reg(input int r);
        if (r == 0) return 0;
        if (BYP && wb_en && int'(wb_rd) == r) return wb_data;
        return mregs[r];
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_alu_valid", alu_valid, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_op1", op1, 0);
            chk("rst_op2", op2, 0);
            chk("rst_rd_out", rd_out, 0);
            for (int i = 0; i < 32; i++) begin
                mregs[i] = 0;
                mpend[i] = 0;
            end
            e_valid = 0; e_ill = 0; e_imm = 0;
            e_op1 = 0; e_op2 = 0; e_f3 = 0; e_f7 = 0; e_rd = 0;
        end else begin
            int  opc, r1, r2, rdst, f3;
            bit  k_op, k_imm, k_lui, legal, hz, rdy, fire;
            logic signed [31:0] u32;
            logic signed [11:0] i12;
            opc  = int'(inst[6:0]);
            rdst = int'(inst[11:7]);
            f3   = int'(inst[14:12]);
            r1   = int'(inst[19:15]);
            r2   = int'(inst[24:20]);
            k_op  = (opc == 'h33);
            k_imm = (opc == 'h13);
            k_lui = (opc == 'h37);
            legal = k_op || k_imm || k_lui;
            hz  = ((k_op || k_imm) && pend_seen(r1)) || (k_op && pend_seen(r2));
            rdy = (!e_valid || !ex_stall) && !hz;

            chk("inst_ready", inst_ready, rdy);
            chk("alu_valid", alu_valid, e_valid);
            chk("illegal", illegal, e_ill);
            if (e_valid) begin
                chk("op1", op1, e_op1);
                chk("op2", op2, e_op2);
                chk("funct3", funct3, e_f3);
                chk("funct7", funct7, e_f7);
                chk("imm", imm, e_imm);
                chk("rd_out", rd_out, e_rd);
            end

            fire  = inst_valid && rdy;
            e_ill = fire && !legal;
            if (fire && legal) begin
                e_valid = 1;
                e_rd    = rdst;
                e_f3    = f3;
                e_op1   = read_reg(r1);
                if (k_op) begin
                    e_op2 = read_reg(r2);
                    e_f7  = int'(inst[31:25]);
                    e_imm = 0;
                end else if (k_imm) begin
                    e_imm = 1;
                    if (f3 == 1 || f3 == 5) begin
                        e_op2 = longint'(inst[25:20]);
                        e_f7  = int'(inst[31:25]) & 'h7E;
                    end else begin
                        i12   = inst[31:20];
                        e_op2 = longint'(i12);
                        e_f7  = 0;
                    end
                end else begin
                    e_op1 = 0;
                    u32   = {inst[31:12], 12'h000};
                    e_op2 = longint'(u32);
                    e_f3  = 0;
                    e_f7  = 0;
                    e_imm = 1;
                end
            end else if (!e_valid || !ex_stall) begin
                e_valid = 0;
            end

            if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
            if (wb_en) mpend[wb_rd] = 0;
            if (fire && legal && rdst != 0) mpend[rdst] = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            w[6:0] = 7'h33;
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k <= 6) w[6:0] = 7'h13;
        else if (k <= 8) w[6:0] = 7'h37;
        else w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'h03;
        return w;
    endfunction

    initial begin
        RST = 1; inst_valid = 0; inst = 0; ex_stall = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk("reset_alu_valid", alu_valid, 0);
        chk("reset_op2", op2, 0);
        chk("reset_ready", inst_ready, 1);

        // addi x1,x0,-5
        tick(); inst = 32'hFFB00093; inst_valid = 1;
        @(negedge CLK); chk("addi_ready", inst_ready, 1);
        // add x3,x1,x1 right behind it
        tick(); inst = 32'h001081B3;
        @(negedge CLK);
        chk("addi_valid", alu_valid, 1);
        chk("addi_op1", op1, 0);
        chk("addi_op2", op2, 64'hFFFFFFFFFFFFFFFB);
        chk("addi_f3", funct3, 0);
        chk("addi_imm", imm, 1);
        chk("addi_rd", rd_out, 1);
        chk("raw_stall_ready", inst_ready, 0);
        tick(); wb_en = 1; wb_rd = 1; wb_data = 64'd7;
        @(negedge CLK); chk("raw_wb_cycle_ready", inst_ready, BYP);
        tick(); wb_en = 0;
`ifndef ID_WB_BYPASS_EN
        @(negedge CLK); chk("raw_after_wb_ready", inst_ready, 1);
        tick();
`endif
        inst_valid = 0;
        @(negedge CLK);
        chk("add_valid", alu_valid, 1);
        chk("add_op1", op1, 7);
        chk("add_op2", op2, 7);
        chk("add_rd", rd_out, 3);

        // srai x2,x1,33
        tick(); inst = 32'h4210D113; inst_valid = 1;
        @(negedge CLK); chk("srai_ready", inst_ready, 1);
        // addi x6,x0,5 offered while ALU stalls
        tick(); inst = 32'h00500313; ex_stall = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("stall_valid", alu_valid, 1);
            chk("srai_op1", op1, 7);
            chk("srai_op2", op2, 33);
            chk("srai_f7", funct7, 7'h20);
            chk("srai_f3", funct3, 5);
            chk("srai_imm", imm, 1);
            chk("srai_rd", rd_out, 2);
            chk("stall_ready", inst_ready, 0);
        end
        tick(); ex_stall = 0;
        @(negedge CLK); chk("unstall_ready", inst_ready, 1);
        tick(); inst = 32'h0000007F;
        @(negedge CLK);
        chk("addi6_op2", op2, 5);
        chk("addi6_rd", rd_out, 6);
        tick(); inst_valid = 0; inst = 0; wb_en = 1; wb_rd = 0; wb_data = 64'hDEAD;
        @(negedge CLK);
        chk("illegal_pulse", illegal, 1);
        chk("illegal_no_valid", alu_valid, 0);
        tick(); wb_en = 0; inst = 32'h00000233; inst_valid = 1;
        @(negedge CLK); chk("illegal_drop", illegal, 0);
        tick(); inst_valid = 0;
        @(negedge CLK);
        chk("x0_op1", op1, 0);
        chk("x0_op2", op2, 0);
        chk("x0_rd", rd_out, 4);

        // reset in the middle of a stall with x1 pending
        tick(); inst = 32'hFFB00093; inst_valid = 1;
        tick(); inst_valid = 0; ex_stall = 1;
        tick();
        #3 RST = 1;
        #1;
        chk("midrst_valid", alu_valid, 0);
        chk("midrst_op2", op2, 0);
        chk("midrst_rd", rd_out, 0);
        tick(); RST = 0; ex_stall = 0; inst = 32'h001082B3; inst_valid = 1;
        @(negedge CLK); chk("post_rst_ready", inst_ready, 1);
        tick(); inst_valid = 0;
        @(negedge CLK);
        chk("post_rst_op1", op1, 0);
        chk("post_rst_op2", op2, 0);
        chk("post_rst_rd", rd_out, 5);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            inst       = rand_inst();
            inst_valid = ($urandom_range(0, 9) < 7);
            ex_stall   = ($urandom_range(0, 3) == 0);
            wb_en      = ($urandom_range(0, 3) == 0);
            wb_rd      = 5'($urandom_range(0, 7));
            wb_data    = {$urandom, $urandom};
        end
        tick();
        inst_valid = 0; ex_stall = 0; wb_en = 0;
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
